load_store_unit: RTL and testbench

//  Sits downstream of the control unit in the RV32I datapath, between the control/ALU stage and data memory.

---
 rtl/load_store_unit.sv | 215 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   RV32I load/store unit between the control/ALU stage and data memory.
//   It decodes the MemWrite mode code and ResultSrc, then runs one access over
//   a req/ready handshake. It handles byte lanes, sign/zero extension of byte
//   loads, and a bounded wait. The single-cycle core is stalled until the
//   access completes.
//
//   FSM: IDLE -> WAIT -> DONE -> IDLE. The minimum latency is 3 cycles.
//
// Parameters
//   ADDR_WIDTH  byte-address width (mem_addr is word aligned)
//   TIMEOUT     maximum number of WAIT cycles before abort; 0 disables it
//
// Ports
//   clk, rst           clock (rising edge), synchronous active-high reset
//   MemWrite[2:0]      001 sw, 011 sb, 010 lb, 110 lbu, 000 lw/none
//   ResultSrc[1:0]     2'b01 marks a load
//   ALUResult          effective byte address
//   WriteData[31:0]    store data (rs2)
//   ReadData[31:0]     formatted load result (registered)
//   Stall              holds PC/regfile while high
//   ErrTimeout         1-cycle pulse when an access is aborted by timeout
//   mem_req/we/be/addr/wdata   memory request side, stable while mem_req=1
//   mem_ready, mem_rdata       memory response side
//   MisalignErr        (only with MISALIGN_TRAP_EN) 1-cycle misaligned-word pulse
//
// Configuration macro
//   MISALIGN_TRAP_EN   traps misaligned sw/lw instead of forcing alignment
// -----------------------------------------------------------------------------
module load_store_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2:0]            MemWrite,
   input  logic [1:0]            ResultSrc,
   input  logic [ADDR_WIDTH-1:0] ALUResult,
   input  logic [31:0]           WriteData,
   output logic [31:0]           ReadData,
   output logic                  Stall,
   output logic                  ErrTimeout,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [3:0]            mem_be,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic                  mem_ready,
   input  logic [31:0]           mem_rdata
`ifdef MISALIGN_TRAP_EN
   ,
   output logic                  MisalignErr
`endif
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;
   typedef enum logic [2:0] {OP_NONE, OP_SW, OP_SB, OP_LW, OP_LB, OP_LBU} op_e;

   state_e                state_q, state_d;
   op_e                   op_q, op_d, op_in;
   logic [1:0]            off_q, off_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [31:0]           read_data_q, read_data_d;
   logic                  err_timeout_q, err_timeout_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic [3:0]            mem_be_q, mem_be_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]           mem_wdata_q, mem_wdata_d;
   logic                  stall_c;
   logic [7:0]            lane;
`ifdef MISALIGN_TRAP_EN
   logic                  misalign_q, misalign_d;
`endif

   // Mode decode. Codes other than the five listed ones are no-ops.
   always_comb begin
      op_in = OP_NONE;
      case (MemWrite)
         3'b001:  op_in = OP_SW;
         3'b011:  op_in = OP_SB;
         3'b000:  if (ResultSrc == 2'b01) op_in = OP_LW;
         3'b010:  if (ResultSrc == 2'b01) op_in = OP_LB;
         3'b110:  if (ResultSrc == 2'b01) op_in = OP_LBU;
         default: op_in = OP_NONE;
      endcase
   end

   // Byte lane selected by the latched address offset (little-endian).
   assign lane = mem_rdata[{off_q, 3'b000} +: 8];

   // NOTE: every signal gets a default before the case, so no path leaves a
   // value unassigned and no latch is inferred.
   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      off_d         = off_q;
      cnt_d         = cnt_q;
      read_data_d   = read_data_q;
      err_timeout_d = 1'b0;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_be_d      = mem_be_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      stall_c       = 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_d    = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (op_in != OP_NONE) begin
               stall_c     = 1'b1;
               op_d        = op_in;
               off_d       = ALUResult[1:0];
               cnt_d       = '0;
               mem_addr_d  = {ALUResult[ADDR_WIDTH-1:2], 2'b00};
               mem_we_d    = (op_in == OP_SW) || (op_in == OP_SB);
               mem_be_d    = (op_in == OP_SB) ? (4'b0001 << ALUResult[1:0]) : 4'b1111;
               mem_wdata_d = (op_in == OP_SB) ? {4{WriteData[7:0]}} : WriteData;
               state_d     = S_WAIT;
               mem_req_d   = 1'b1;
`ifdef MISALIGN_TRAP_EN
               // Misaligned word access: skip the bus entirely, no store.
               if (((op_in == OP_SW) || (op_in == OP_LW)) && (ALUResult[1:0] != 2'b00)) begin
                  state_d     = S_DONE;
                  mem_req_d   = 1'b0;
                  mem_we_d    = 1'b0;
                  read_data_d = '0;
                  misalign_d  = 1'b1;
               end
`endif
            end
         end
         S_WAIT: begin
            stall_c = 1'b1;
            if (mem_ready) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               state_d   = S_DONE;
               case (op_q)
                  OP_LW:   read_data_d = mem_rdata;
                  OP_LB:   read_data_d = {{24{lane[7]}}, lane};
                  OP_LBU:  read_data_d = {24'h0, lane};
                  default: read_data_d = read_data_q;
               endcase
            end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
               // cnt_q counts completed WAIT cycles, so this is the last one.
               mem_req_d     = 1'b0;
               mem_we_d      = 1'b0;
               read_data_d   = '0;
               err_timeout_d = 1'b1;
               state_d       = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments only, so all flops
   // sample the same pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         op_q          <= OP_NONE;
         off_q         <= '0;
         cnt_q         <= '0;
         read_data_q   <= '0;
         err_timeout_q <= 1'b0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_be_q      <= '0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
`ifdef MISALIGN_TRAP_EN
         misalign_q    <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         off_q         <= off_d;
         cnt_q         <= cnt_d;
         read_data_q   <= read_data_d;
         err_timeout_q <= err_timeout_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_be_q      <= mem_be_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
`ifdef MISALIGN_TRAP_EN
         misalign_q    <= misalign_d;
`endif
      end
   end

   // Stall is combinational so the core freezes in the issuing cycle.
   assign Stall      = stall_c & ~rst;
   assign ReadData   = read_data_q;
   assign ErrTimeout = err_timeout_q;
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_be     = mem_be_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
`ifdef MISALIGN_TRAP_EN
   assign MisalignErr = misalign_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Self-checking bench for load_store_unit (TIMEOUT = 4).
//   It applies a directed vector table, a few hand-written multi-cycle
//   sequences (reset, timeout, reset mid-access, misaligned word), and
//   randomized accesses checked against a behavioural model.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  MemWrite;
   logic [1:0]  ResultSrc;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        Stall;
   logic        ErrTimeout;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        MisalignErr;

   int checks = 0;
   int errors = 0;

   load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .MemWrite(MemWrite), .ResultSrc(ResultSrc),
      .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData),
      .Stall(Stall), .ErrTimeout(ErrTimeout), .mem_req(mem_req), .mem_we(mem_we),
      .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
`ifdef MISALIGN_TRAP_EN
      , .MisalignErr(MisalignErr)
`endif
   );
`ifndef MISALIGN_TRAP_EN
   assign MisalignErr = 1'b0;
`endif

   always #5 clk = ~clk;

   typedef struct {
      bit          access;
      int          req;
      logic [3:0]  be;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      logic        mis;
      bit          chk_wd;
      bit          chk_rd;
   } exp_t;

   typedef struct {
      logic        stall_first;
      bit          finished;
      bit          stall_bad;
      bit          unstable;
      int          req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      logic        mis;
      logic        pulse_after;
   } obs_t;

   typedef struct {
      string       name;
      logic [2:0]  mw;
      logic [1:0]  rs;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      int          delay;
      int          exp_req;
      logic [3:0]  exp_be;
      logic        exp_we;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      bit          chk_wd;
      bit          chk_rd;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference behaviour computed straight from the mode/lane rules.
   function automatic exp_t model(input logic [2:0] mw, input logic [1:0] rs,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [31:0] rd, input int delay);
      exp_t e;
      bit   is_store, is_load, timeout;
      int   b;
      int   byte_v;
      e        = '{default: '0};
      is_store = (mw == 3'b001) || (mw == 3'b011);
      is_load  = (rs == 2'b01) && ((mw == 3'b000) || (mw == 3'b010) || (mw == 3'b110));
      b        = int'(addr[1:0]);
      e.access = is_store || is_load;
      if (!e.access) return e;
`ifdef MISALIGN_TRAP_EN
      if (((mw == 3'b001) || (mw == 3'b000)) && b != 0) begin
         e.mis    = 1'b1;
         e.rdata  = 32'h0;
         e.chk_rd = 1'b1;
         return e;
      end
`endif
      timeout  = (TO != 0) && (delay >= TO);
      e.req    = timeout ? TO : delay + 1;
      e.err    = timeout;
      e.we     = is_store;
      e.be     = (mw == 3'b011) ? 4'(1 << b) : 4'hF;
      e.addr   = addr & ~32'd3;
      e.chk_wd = is_store;
      e.wdata  = (mw == 3'b011) ? wd[7:0] * 32'h01010101 : wd;
      e.chk_rd = is_load || timeout;
      byte_v   = int'((rd >> (8 * b)) & 32'hFF);
      if (timeout)              e.rdata = 32'h0;
      else if (mw == 3'b000)    e.rdata = rd;
      else if (mw == 3'b010)    e.rdata = (byte_v >= 128) ? 32'(byte_v - 256) : 32'(byte_v);
      else                      e.rdata = 32'(byte_v);
      return e;
   endfunction

   // One core instruction: drive it in IDLE, act as memory, observe until DONE.
   task automatic run_access(input logic [2:0] mw, input logic [1:0] rs,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rd, input int delay, output obs_t o);
      int n;
      o = '{default: '0};
      @(negedge clk);
      MemWrite = mw; ResultSrc = rs; ALUResult = addr; WriteData = wd;
      mem_ready = 1'b0; mem_rdata = $urandom;
      #1 o.stall_first = Stall;
      n = 0;
      for (int cyc = 0; cyc < 64 && !o.finished; cyc++) begin
         @(posedge clk); #1;
         if (mem_req) begin
            if (n == 0) begin
               o.we = mem_we; o.be = mem_be; o.addr = mem_addr; o.wdata = mem_wdata;
            end else if (mem_we !== o.we || mem_be !== o.be || mem_addr !== o.addr ||
                         mem_wdata !== o.wdata) begin
               o.unstable = 1'b1;
            end
            if (Stall !== 1'b1) o.stall_bad = 1'b1;
            mem_ready = (n == delay);
            mem_rdata = (n == delay) ? rd : $urandom;
            n++;
         end else begin
            mem_ready = 1'b0;
            if (Stall !== 1'b0) o.stall_bad = 1'b1;
            o.rdata = ReadData; o.err = ErrTimeout; o.mis = MisalignErr;
            MemWrite = 3'b000; ResultSrc = 2'b00;
            o.finished = 1'b1;
         end
      end
      o.req = n;
      @(posedge clk); #1;
      o.pulse_after = ErrTimeout | MisalignErr;
   endtask

   task automatic check_obs(input string tag, input obs_t o, input exp_t e);
      check({tag, ".stall_first"}, 32'(o.stall_first), 32'(e.access));
      check({tag, ".done"}, 32'(o.finished), 32'd1);
      check({tag, ".stall_seq"}, 32'(o.stall_bad), 32'd0);
      check({tag, ".req_cycles"}, 32'(o.req), 32'(e.req));
      if (e.req > 0) begin
         check({tag, ".we"}, 32'(o.we), 32'(e.we));
         check({tag, ".be"}, 32'(o.be), 32'(e.be));
         check({tag, ".addr"}, o.addr, e.addr);
         check({tag, ".stable"}, 32'(o.unstable), 32'd0);
         if (e.chk_wd) check({tag, ".wdata"}, o.wdata, e.wdata);
      end
      if (e.chk_rd) check({tag, ".rdata"}, o.rdata, e.rdata);
      check({tag, ".err"}, 32'(o.err), 32'(e.err));
      check({tag, ".mis"}, 32'(o.mis), 32'(e.mis));
      check({tag, ".pulse_1cyc"}, 32'(o.pulse_after), 32'd0);
   endtask

   vec_t vecs[10];

   initial begin
      obs_t        o;
      exp_t        e;
      logic [31:0] rd_hold;
      int          req_seen;
      logic [2:0]  codes[8];

      // Directed table (TIMEOUT = 4): inputs and hand-derived expectations.
      vecs[0] = '{"sw_basic",   3'b001, 2'b00, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1, 4'b1111, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{"sb_lane3",   3'b011, 2'b00, 32'h103, 32'h000000A5, 32'h0, 0, 1, 4'b1000, 1'b1, 32'h100, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{"lb_neg",     3'b010, 2'b01, 32'h102, 32'h0, 32'h0080FF00, 0, 1, 4'b1111, 1'b0, 32'h100, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{"lbu",        3'b110, 2'b01, 32'h102, 32'h0, 32'h0080FF00, 0, 1, 4'b1111, 1'b0, 32'h100, 32'h0, 32'h00000080, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{"lw_timeout", 3'b000, 2'b01, 32'h200, 32'h0, 32'h12345678, 9, 4, 4'b1111, 1'b0, 32'h200, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{"lw_delay2",  3'b000, 2'b01, 32'h204, 32'h0, 32'h12345678, 2, 3, 4'b1111, 1'b0, 32'h204, 32'h0, 32'h12345678, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{"lw_last_ok", 3'b000, 2'b01, 32'h208, 32'h0, 32'h87654321, 3, 4, 4'b1111, 1'b0, 32'h208, 32'h0, 32'h87654321, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{"lb_pos",     3'b010, 2'b01, 32'h301, 32'h0, 32'h00007F00, 0, 1, 4'b1111, 1'b0, 32'h300, 32'h0, 32'h0000007F, 1'b0, 1'b0, 1'b1};
      vecs[8] = '{"sb_lane0",   3'b011, 2'b00, 32'h400, 32'h00001234, 32'h0, 1, 2, 4'b0001, 1'b1, 32'h400, 32'h34343434, 32'h0, 1'b0, 1'b1, 1'b0};
      vecs[9] = '{"sw_timeout", 3'b001, 2'b00, 32'h500, 32'hCAFEBABE, 32'h0, 7, 4, 4'b1111, 1'b1, 32'h500, 32'hCAFEBABE, 32'h0, 1'b1, 1'b1, 1'b1};

      // Reset with an access pending: Stall must stay low while rst=1.
      rst = 1'b1; MemWrite = 3'b001; ResultSrc = 2'b00; ALUResult = 32'h100;
      WriteData = 32'h1; mem_ready = 1'b0; mem_rdata = 32'h0;
      #1 check("reset.stall_forced", 32'(Stall), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      check("reset.ReadData", ReadData, 32'h0);
      check("reset.mem_req", 32'(mem_req), 32'd0);
      check("reset.mem_we", 32'(mem_we), 32'd0);
      check("reset.mem_be", 32'(mem_be), 32'd0);
      check("reset.mem_addr", mem_addr, 32'h0);
      check("reset.mem_wdata", mem_wdata, 32'h0);
      check("reset.ErrTimeout", 32'(ErrTimeout), 32'd0);
      check("reset.MisalignErr", 32'(MisalignErr), 32'd0);
      @(negedge clk);
      rst = 1'b0; MemWrite = 3'b000; ResultSrc = 2'b00;

      // Table-driven vectors.
      for (int i = 0; i < 10; i++) begin
         run_access(vecs[i].mw, vecs[i].rs, vecs[i].addr, vecs[i].wd, vecs[i].rd, vecs[i].delay, o);
         e = '{access: 1'b1, req: vecs[i].exp_req, be: vecs[i].exp_be, we: vecs[i].exp_we,
               addr: vecs[i].exp_addr, wdata: vecs[i].exp_wdata, rdata: vecs[i].exp_rdata,
               err: vecs[i].exp_err, mis: 1'b0, chk_wd: vecs[i].chk_wd, chk_rd: vecs[i].chk_rd};
         check_obs(vecs[i].name, o, e);
      end

      // No-op codes and a load code without ResultSrc=01 do not stall.
      run_access(3'b100, 2'b01, 32'h600, 32'h0, 32'h0, 0, o);
      check("noop100.stall", 32'(o.stall_first), 32'd0);
      check("noop100.req", 32'(o.req), 32'd0);
      run_access(3'b010, 2'b00, 32'h600, 32'h0, 32'h0, 0, o);
      check("lb_no_rs.stall", 32'(o.stall_first), 32'd0);
      check("lb_no_rs.req", 32'(o.req), 32'd0);

      // mem_ready asserted while idle is ignored.
      @(negedge clk);
      rd_hold = ReadData; mem_ready = 1'b1; mem_rdata = 32'h5A5A5A5A;
      req_seen = 0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         if (mem_req !== 1'b0 || Stall !== 1'b0) req_seen++;
      end
      check("idle_ready.no_activity", 32'(req_seen), 32'd0);
      check("idle_ready.ReadData", ReadData, rd_hold);
      mem_ready = 1'b0;

      // Reset asserted in WAIT of a store: abort, no retry afterwards.
      @(negedge clk);
      MemWrite = 3'b001; ResultSrc = 2'b00; ALUResult = 32'h700; WriteData = 32'h11111111;
      @(posedge clk); #1;
      check("rst_wait.in_wait", 32'(mem_req), 32'd1);
      rst = 1'b1; MemWrite = 3'b000;
      #1 check("rst_wait.stall_forced", 32'(Stall), 32'd0);
      @(posedge clk); #1;
      check("rst_wait.req_dropped", 32'(mem_req), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      req_seen = 0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (mem_req !== 1'b0) req_seen++;
      end
      check("rst_wait.no_retry", 32'(req_seen), 32'd0);
      run_access(3'b000, 2'b01, 32'h704, 32'h0, 32'h0BADF00D, 0, o);
      check_obs("rst_wait.lw_after", o, model(3'b000, 2'b01, 32'h704, 32'h0, 32'h0BADF00D, 0));

      // Misaligned word access.
      run_access(3'b000, 2'b01, 32'h101, 32'h0, 32'hCAFEF00D, 0, o);
`ifdef MISALIGN_TRAP_EN
      check("mis_lw.stall", 32'(o.stall_first), 32'd1);
      check("mis_lw.req", 32'(o.req), 32'd0);
      check("mis_lw.MisalignErr", 32'(o.mis), 32'd1);
      check("mis_lw.ReadData", o.rdata, 32'h0);
      check("mis_lw.pulse_1cyc", 32'(o.pulse_after), 32'd0);
      run_access(3'b001, 2'b00, 32'h102, 32'hFFFFFFFF, 32'h0, 0, o);
      check("mis_sw.req", 32'(o.req), 32'd0);
      check("mis_sw.MisalignErr", 32'(o.mis), 32'd1);
`else
      check("align_lw.req", 32'(o.req), 32'd1);
      check("align_lw.addr", o.addr, 32'h100);
      check("align_lw.be", 32'(o.be), 32'hF);
      check("align_lw.ReadData", o.rdata, 32'hCAFEF00D);
`endif

      // Randomized accesses against the model.
      codes = '{3'b001, 3'b011, 3'b000, 3'b010, 3'b110, 3'b100, 3'b101, 3'b111};
      for (int i = 0; i < 60; i++) begin
         logic [2:0]  mw;
         logic [1:0]  rs;
         logic [31:0] a, wd, rd;
         int          dly;
         mw  = codes[$urandom_range(0, 7)];
         rs  = ($urandom_range(0, 3) != 0) ? 2'b01 : 2'($urandom_range(0, 3));
         a   = $urandom; wd = $urandom; rd = $urandom;
         dly = $urandom_range(0, TO + 1);
         run_access(mw, rs, a, wd, rd, dly, o);
         check_obs($sformatf("rand%0d", i), o, model(mw, rs, a, wd, rd, dly));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
